bexkat1_bank_ctrl: RTL and testbench

//  Owns the bank select and the single write port of the banked register file.

---
 rtl/bexkat1_bank_ctrl.sv | 135 +++++++++++++
 tb/tb_bexkat1_bank_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bexkat1_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bexkat1_bank_ctrl
// Brief    : Register-file bank select with a LIFO of previous banks for
//            nested trap entry/exit, plus the register-file write port mux.
//            Define BEXKAT1_BANK_CLEAR_EN to zero-fill the banked registers
//            of every newly entered bank (pipeline stalls via busy_o).
// Revision : 1.0 - initial release
// ============================================================================
module bexkat1_bank_ctrl #(
  parameter int WIDTH = 32,
  parameter int WINP  = 4,
  parameter int BANKS = 13,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enter_i,
  input  logic [3:0]                   enter_bank_i,
  input  logic                         leave_i,
  input  logic [WINP-1:0]              wb_addr_i,
  input  logic [WIDTH-1:0]             wb_data_i,
  input  logic [1:0]                   wb_en_i,
  output logic                         wb_ready_o,
  output logic [3:0]                   bank_o,
  output logic [WINP-1:0]              rf_write_addr_o,
  output logic [WIDTH-1:0]             rf_write_data_o,
  output logic [1:0]                   rf_write_en_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         err_o
);

  localparam int             DW         = $clog2(DEPTH+1);
  localparam logic [4:0]     c_bank_lim = 5'(BANKS);
  localparam logic [DW-1:0]  c_depth_max = DW'(DEPTH);

  logic [3:0]    r_bank;
  logic [3:0]    r_stack [DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_err;

  logic w_busy;
  logic w_enter_ok;
  logic w_leave_ok;
  logic w_err;

  // Enter wins over a simultaneous leave; every rejected or dropped request flags an error.
  assign w_enter_ok = enter_i && !w_busy &&
                      ({1'b0, enter_bank_i} < c_bank_lim) &&
                      (r_depth != c_depth_max);
  assign w_leave_ok = leave_i && !enter_i && !w_busy && (r_depth != '0);
  assign w_err      = (enter_i && !w_enter_ok) || (leave_i && !w_leave_ok);

  // Bank register and shift-style stack: entry 0 always holds the most recent push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bank  <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_err <= w_err;
      if (w_enter_ok) begin
        r_stack[0] <= r_bank;
        for (int i = 1; i < DEPTH; i++) r_stack[i] <= r_stack[i-1];
        r_bank  <= enter_bank_i;
        r_depth <= r_depth + 1'b1;
      end else if (w_leave_ok) begin
        r_bank <= r_stack[0];
        for (int i = 0; i < DEPTH-1; i++) r_stack[i] <= r_stack[i+1];
        r_stack[DEPTH-1] <= '0;
        r_depth <= r_depth - 1'b1;
      end
    end
  end

`ifdef BEXKAT1_BANK_CLEAR_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WINP-2:0] r_clr_idx;

  // State register and clear index; the index restarts at zero whenever idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= (r_state == ST_CLEAR) ? r_clr_idx + 1'b1 : '0;
    end
  end

  // Next state: an accepted enter starts a sweep over every banked register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_enter_ok) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_idx == '1) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);
`else
  assign w_busy = 1'b0;
`endif

  // Write-port mux: pipeline pass-through, overridden by the zero-fill sweep.
  always_comb begin
    rf_write_addr_o = wb_addr_i;
    rf_write_data_o = wb_data_i;
    rf_write_en_o   = wb_en_i;
`ifdef BEXKAT1_BANK_CLEAR_EN
    if (w_busy) begin
      rf_write_addr_o = {1'b1, r_clr_idx};
      rf_write_data_o = '0;
      rf_write_en_o   = 2'b11;
    end
`endif
  end

  assign bank_o     = r_bank;
  assign depth_o    = r_depth;
  assign err_o      = r_err;
  assign busy_o     = w_busy;
  assign wb_ready_o = !w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bexkat1_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bexkat1_bank_ctrl
// Brief    : Directed scoreboard bench for bexkat1_bank_ctrl. Stimulus pushes
//            hand-computed expectations; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bexkat1_bank_ctrl;

`ifdef BEXKAT1_BANK_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enter_i = 1'b0;
  logic [3:0]  enter_bank_i = '0;
  logic        leave_i = 1'b0;
  logic [3:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [1:0]  wb_en_i = '0;
  logic        wb_ready_o;
  logic [3:0]  bank_o;
  logic [3:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;
  logic [1:0]  rf_write_en_o;
  logic        busy_o;
  logic [2:0]  depth_o;
  logic        err_o;

  bexkat1_bank_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enter_i         (enter_i),
    .enter_bank_i    (enter_bank_i),
    .leave_i         (leave_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .wb_en_i         (wb_en_i),
    .wb_ready_o      (wb_ready_o),
    .bank_o          (bank_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o),
    .rf_write_en_o   (rf_write_en_o),
    .busy_o          (busy_o),
    .depth_o         (depth_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  bank;
    logic [2:0]  depth;
    logic        err;
    logic        busy;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  wen;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared at the falling edge.
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("bank_o",          32'(bank_o),          32'(e.bank));
      chk("depth_o",         32'(depth_o),         32'(e.depth));
      chk("err_o",           32'(err_o),           32'(e.err));
      chk("busy_o",          32'(busy_o),          32'(e.busy));
      chk("wb_ready_o",      32'(wb_ready_o),      32'(!e.busy));
      chk("rf_write_addr_o", 32'(rf_write_addr_o), 32'(e.waddr));
      chk("rf_write_data_o", rf_write_data_o,      e.wdata);
      chk("rf_write_en_o",   32'(rf_write_en_o),   32'(e.wen));
    end
  end

  // One cycle of stimulus plus its expected observation in that same cycle.
  task automatic step(input logic rst, input logic en, input logic [3:0] eb, input logic lv,
                      input logic [3:0] wa, input logic [31:0] wd, input logic [1:0] we,
                      input logic [3:0] xb, input logic [2:0] xd, input logic xerr,
                      input logic xbusy, input logic [2:0] xidx);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = rst; enter_i = en; enter_bank_i = eb; leave_i = lv;
    wb_addr_i = wa; wb_data_i = wd; wb_en_i = we;
    e.bank  = xb;
    e.depth = xd;
    e.err   = xerr;
    e.busy  = xbusy;
    e.waddr = xbusy ? {1'b1, xidx} : wa;
    e.wdata = xbusy ? 32'h0 : wd;
    e.wen   = xbusy ? 2'b11 : we;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    // 1: reset state and zero-latency pass-through
    step(0,0,4'd0,0, 4'd3, 32'hDEADBEEF, 2'b11,  4'd0,3'd0,0,0,3'd0);
    step(0,0,4'd0,0, 4'd12,32'h000000A5, 2'b01,  4'd0,3'd0,0,0,3'd0);
    // 2: enter 5 (writeback that cycle sees bank 0), enter 9, leave twice
    step(0,1,4'd5,0, 4'd9, 32'h12345678, 2'b10,  4'd0,3'd0,0,0,3'd0);
    step(0,1,4'd9,0, 4'd1, 32'h0000FFFF, 2'b00,  4'd5,3'd1,0,0,3'd0);
    step(0,0,4'd0,1, 4'd8, 32'hCAFEF00D, 2'b11,  4'd9,3'd2,0,0,3'd0);
    step(0,0,4'd0,1, 4'd15,32'h80000001, 2'b11,  4'd5,3'd1,0,0,3'd0);
    step(0,0,4'd0,0, 4'd0, 32'h00000000, 2'b00,  4'd0,3'd0,0,0,3'd0);
    // 3: leave at depth 0, enter bank 13, then fill to depth 4 and enter again
    step(0,0,4'd0,1, 4'd2, 32'h11111111, 2'b01,  4'd0,3'd0,0,0,3'd0);
    step(0,1,4'd13,0,4'd4, 32'h22222222, 2'b10,  4'd0,3'd0,1,0,3'd0);
    step(0,1,4'd1,0, 4'd5, 32'h33333333, 2'b11,  4'd0,3'd0,1,0,3'd0);
    step(0,1,4'd12,0,4'd6, 32'h44444444, 2'b00,  4'd1,3'd1,0,0,3'd0);
    step(0,1,4'd12,0,4'd7, 32'h55555555, 2'b01,  4'd12,3'd2,0,0,3'd0);
    step(0,1,4'd4,0, 4'd10,32'h66666666, 2'b10,  4'd12,3'd3,0,0,3'd0);
    step(0,1,4'd7,0, 4'd11,32'h77777777, 2'b11,  4'd4,3'd4,0,0,3'd0);
    step(0,0,4'd0,0, 4'd13,32'h88888888, 2'b11,  4'd4,3'd4,1,0,3'd0);
    step(0,0,4'd0,1, 4'd14,32'h99999999, 2'b11,  4'd4,3'd4,0,0,3'd0);
    step(0,0,4'd0,1, 4'd3, 32'hAAAAAAAA, 2'b01,  4'd12,3'd3,0,0,3'd0);
    step(0,0,4'd0,1, 4'd3, 32'hBBBBBBBB, 2'b01,  4'd12,3'd2,0,0,3'd0);
    // 4: simultaneous enter(2)+leave at depth 1
    step(0,1,4'd2,1, 4'd1, 32'hCCCCCCCC, 2'b10,  4'd1,3'd1,0,0,3'd0);
    step(0,0,4'd0,0, 4'd1, 32'hDDDDDDDD, 2'b10,  4'd2,3'd2,1,0,3'd0);
    step(0,0,4'd0,1, 4'd0, 32'h0, 2'b00,         4'd2,3'd2,0,0,3'd0);
    step(0,0,4'd0,1, 4'd0, 32'h0, 2'b00,         4'd1,3'd1,0,0,3'd0);
    step(0,0,4'd0,0, 4'd0, 32'h0, 2'b00,         4'd0,3'd0,0,0,3'd0);
`ifdef BEXKAT1_BANK_CLEAR_EN
    // 5: enter bank 3 starts an 8-cycle clear; enter during it is rejected
    step(0,1,4'd3,0, 4'd2, 32'h01010101, 2'b11,  4'd0,3'd0,0,0,3'd0);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd0);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd1);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd2);
    step(0,1,4'd6,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd3);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,1,1,3'd4);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd5);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd6);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,1,3'd7);
    step(0,0,4'd0,0, 4'd2, 32'h01010101, 2'b11,  4'd3,3'd1,0,0,3'd0);
    step(0,0,4'd0,1, 4'd5, 32'h02020202, 2'b01,  4'd3,3'd1,0,0,3'd0);
    step(0,0,4'd0,0, 4'd5, 32'h02020202, 2'b01,  4'd0,3'd0,0,0,3'd0);
`endif
    // 6: reset four cycles into the sequence started by an enter of bank 5
    step(0,1,4'd5,0, 4'd6, 32'h5A5A5A5A, 2'b11,  4'd0,3'd0,0,0,3'd0);
    step(0,0,4'd0,0, 4'd6, 32'h5A5A5A5A, 2'b11,  4'd5,3'd1,0,CLR,3'd0);
    step(0,0,4'd0,0, 4'd6, 32'h5A5A5A5A, 2'b11,  4'd5,3'd1,0,CLR,3'd1);
    step(0,0,4'd0,0, 4'd6, 32'h5A5A5A5A, 2'b11,  4'd5,3'd1,0,CLR,3'd2);
    step(1,0,4'd0,0, 4'd6, 32'h5A5A5A5A, 2'b11,  4'd5,3'd1,0,CLR,3'd3);
    step(0,0,4'd0,0, 4'd7, 32'hA5A5A5A5, 2'b10,  4'd0,3'd0,0,0,3'd0);
    step(0,0,4'd0,0, 4'd9, 32'h0F0F0F0F, 2'b01,  4'd0,3'd0,0,0,3'd0);
    @(negedge clk_i);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
